uart_rcv: RTL

- 8N1 UART receiver: the receive end of the link driven by uart_tx, which mimics the BLE module.
- Sits inside the Segway command path and feeds received bytes to the command processor.
- Also usable standalone in benches as a loopback checker on uart_tx's TX line.
- Samples mid-bit, rejects start-bit glitches, and presents each byte with a rdy/clr_rdy handshake plus framing and overrun flags.

---
 rtl/uart_rcv.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling with start-glitch
// rejection, rdy/clr_rdy handshake, framing and overrun flags.
module uart_rcv #(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err,
   output logic       ovr_err
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // Reloads are one less than the interval because the tick fires on zero.
   localparam logic [11:0] FULL_RELOAD = 12'(BAUD_DIV - 1);
   localparam logic [11:0] HALF_RELOAD = 12'(BAUD_DIV / 2 - 1);

   state_t      state_q, state_d;
   logic        rx_ff1_q, rx_s_q;
   logic [11:0] baud_q, baud_d;
   logic [3:0]  bit_q, bit_d;
   logic [8:0]  shift_q, shift_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rdy_q, rdy_d;
   logic        frm_q, frm_d;
   logic        ovr_q, ovr_d;
   logic        unread_q, unread_d;
   logic        armed_q, armed_d;
   logic        tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_ff1_q  <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_data_q <= '0;
         rdy_q     <= 1'b0;
         frm_q     <= 1'b0;
         ovr_q     <= 1'b0;
         unread_q  <= 1'b0;
         armed_q   <= 1'b1;
      end else begin
         rx_ff1_q  <= RX;
         rx_s_q    <= rx_ff1_q;
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         rdy_q     <= rdy_d;
         frm_q     <= frm_d;
         ovr_q     <= ovr_d;
         unread_q  <= unread_d;
         armed_q   <= armed_d;
      end
   end

   assign tick = (baud_q == 12'd0);

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      rdy_d     = rdy_q;
      frm_d     = frm_q;
      ovr_d     = ovr_q;
      unread_d  = unread_q;
      armed_d   = armed_q;

      // unread_q remembers an unconsumed byte even after a new start clears rdy.
      if (clr_rdy) begin
         rdy_d    = 1'b0;
         unread_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (rx_s_q) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               baud_d  = HALF_RELOAD;
               bit_d   = 4'd0;
               state_d = START;
            end
         end
         START: begin
            if (!tick) begin
               baud_d = baud_q - 12'd1;
            end else if (rx_s_q) begin
               state_d = IDLE;
            end else begin
               baud_d  = FULL_RELOAD;
               bit_d   = bit_q + 4'd1;
               rdy_d   = 1'b0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (!tick) begin
               baud_d = baud_q - 12'd1;
            end else begin
               shift_d = {rx_s_q, shift_q[8:1]};
               bit_d   = bit_q + 4'd1;
               baud_d  = FULL_RELOAD;
               if (bit_q == 4'd8) state_d = STOP;
            end
         end
         STOP: begin
            if (!tick) begin
               baud_d = baud_q - 12'd1;
            end else begin
               rx_data_d = shift_q[8:1];
               frm_d     = ~rx_s_q;
               ovr_d     = unread_q;
               rdy_d     = 1'b1;
               unread_d  = 1'b1;
               armed_d   = rx_s_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_data = rx_data_q;
   assign rdy     = rdy_q;
   assign frm_err = frm_q;
   assign ovr_err = ovr_q;

endmodule
